// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle MIPS sequencer.
package mc_pkg;

    localparam int unsigned MC_STATE_W = 3;

    typedef enum logic [MC_STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_ERR    = 3'd7
    } mc_state_e;

    // Counter must be able to hold MAX_WAIT itself.
    function automatic int unsigned mc_wait_w(input int unsigned max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-request wait counter, shared by the FETCH and MEM handshakes.
module mc_wait_timer
    import mc_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic timeout
);

    localparam int unsigned W = mc_wait_w(MAX_WAIT);
    localparam logic [W-1:0] LIMIT = W'(MAX_WAIT);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Only fires while still waiting, so an ack on the limit cycle wins.
    assign timeout = count && (cnt_q == LIMIT);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle instruction sequencer: phase FSM, memory handshakes, strobe gating, retire count.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  dec_gp_we,
    input  logic                  dec_dm_we,
    input  logic                  dec_load,
    input  logic                  im_ack,
    input  logic                  dm_ack,
    output logic                  im_req,
    output logic                  ir_we,
    output logic                  dm_req,
    output logic                  dm_we,
    output logic                  gp_we,
    output logic                  pc_we,
    output logic [MC_STATE_W-1:0] state,
    output logic                  err,
    output logic [31:0]           instret
);

    mc_state_e   state_q, state_d;
    logic [31:0] instret_q;
    logic        retire;
    logic        wait_cnt;
    logic        timeout;

    assign wait_cnt = ((state_q == ST_FETCH) && !im_ack) ||
                      ((state_q == ST_MEM)   && !dm_ack);

    mc_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait (
        .clk     (clk),
        .reset   (reset),
        .clear   (!wait_cnt),
        .count   (wait_cnt),
        .timeout (timeout)
    );

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        unique case (state_q)
            ST_IDLE:   if (run) state_d = ST_FETCH;
            ST_FETCH: begin
                if (im_ack)       state_d = ST_DECODE;
                else if (timeout) state_d = ST_ERR;
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = (dec_load || dec_dm_we) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (dm_ack) begin
                    if (dec_dm_we) retire  = 1'b1;
                    else           state_d = ST_WB;
                end else if (timeout) begin
                    state_d = ST_ERR;
                end
            end
            ST_WB:     retire = 1'b1;
            ST_ERR:    state_d = ST_ERR;
            default:   state_d = ST_IDLE;
        endcase
        if (retire) state_d = run ? ST_FETCH : ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) instret_q <= instret_q + 32'd1;
        end
    end

    // Requests follow state; write strobes also need the live ack/decoder inputs.
    always_comb begin
        im_req = (state_q == ST_FETCH);
        ir_we  = (state_q == ST_FETCH) && im_ack;
        dm_req = (state_q == ST_MEM);
        dm_we  = (state_q == ST_MEM) && dec_dm_we;
        gp_we  = (state_q == ST_WB) && dec_gp_we;
        pc_we  = (state_q == ST_WB) || ((state_q == ST_MEM) && dm_ack && dec_dm_we);
    end

    assign state   = state_q;
    assign err     = (state_q == ST_ERR);
    assign instret = instret_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed-vector scoreboard bench for mc_ctrl (MAX_WAIT=4).
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        dec_gp_we = 1'b0;
    logic        dec_dm_we = 1'b0;
    logic        dec_load = 1'b0;
    logic        im_ack = 1'b0;
    logic        dm_ack = 1'b0;
    logic        im_req, ir_we, dm_req, dm_we, gp_we, pc_we, err;
    logic [2:0]  state;
    logic [31:0] instret;

    mc_ctrl #(.MAX_WAIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .dec_gp_we (dec_gp_we),
        .dec_dm_we (dec_dm_we),
        .dec_load  (dec_load),
        .im_ack    (im_ack),
        .dm_ack    (dm_ack),
        .im_req    (im_req),
        .ir_we     (ir_we),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .gp_we     (gp_we),
        .pc_we     (pc_we),
        .state     (state),
        .err       (err),
        .instret   (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  st;
        logic [6:0]  o;   // {im_req, ir_we, dm_req, dm_we, gp_we, pc_we, err}
        logic [31:0] ic;
        int unsigned id;
    } exp_t;

    exp_t        expq[$];
    int unsigned n_checks = 0;
    int unsigned n_errs = 0;
    int unsigned cyc_n = 0;

    task automatic chk(input string name, input int unsigned id,
                       input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errs++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, id, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("state",   e.id, {29'd0, state}, {29'd0, e.st});
            chk("strobes", e.id, {25'd0, im_req, ir_we, dm_req, dm_we, gp_we, pc_we, err},
                {25'd0, e.o});
            chk("instret", e.id, instret, e.ic);
        end
    end

    // One cycle: drive inputs just after the edge, queue what the outputs must be this cycle.
    task automatic cyc(input logic r, rn, gw, sw, ld, ia, da,
                       input logic [2:0] es, input logic [5:0] eo, input logic [31:0] ei);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; run = rn; dec_gp_we = gw; dec_dm_we = sw; dec_load = ld;
        im_ack = ia; dm_ack = da;
        e.st = es;
        e.o  = {eo, (es == 3'd7)};
        e.ic = ei;
        e.id = cyc_n;
        cyc_n++;
        expq.push_back(e);
    endtask

    initial begin
        // reset
        cyc(1,0,0,0,0,0,0, 3'd0, 6'b000000, 32'd0);
        cyc(1,0,0,0,0,0,0, 3'd0, 6'b000000, 32'd0);
        // ALU
        cyc(0,1,1,0,0,1,0, 3'd0, 6'b000000, 32'd0);
        cyc(0,1,1,0,0,1,0, 3'd1, 6'b110000, 32'd0);
        cyc(0,1,1,0,0,1,0, 3'd2, 6'b000000, 32'd0);
        cyc(0,1,1,0,0,1,0, 3'd3, 6'b000000, 32'd0);
        cyc(0,1,1,0,0,1,0, 3'd5, 6'b000011, 32'd0);
        // load, dm_ack after 3 waits
        cyc(0,1,1,0,1,1,0, 3'd1, 6'b110000, 32'd1);
        cyc(0,1,1,0,1,1,0, 3'd2, 6'b000000, 32'd1);
        cyc(0,1,1,0,1,1,0, 3'd3, 6'b000000, 32'd1);
        cyc(0,1,1,0,1,1,0, 3'd4, 6'b001000, 32'd1);
        cyc(0,1,1,0,1,1,0, 3'd4, 6'b001000, 32'd1);
        cyc(0,1,1,0,1,1,0, 3'd4, 6'b001000, 32'd1);
        cyc(0,1,1,0,1,1,1, 3'd4, 6'b001000, 32'd1);
        cyc(0,1,1,0,1,1,0, 3'd5, 6'b000011, 32'd1);
        // store
        cyc(0,1,0,1,0,1,0, 3'd1, 6'b110000, 32'd2);
        cyc(0,1,0,1,0,1,0, 3'd2, 6'b000000, 32'd2);
        cyc(0,1,0,1,0,1,0, 3'd3, 6'b000000, 32'd2);
        cyc(0,1,0,1,0,1,1, 3'd4, 6'b001101, 32'd2);
        // ALU with run dropped in EXEC, stray acks afterwards
        cyc(0,1,1,0,0,1,1, 3'd1, 6'b110000, 32'd3);
        cyc(0,1,1,0,0,1,0, 3'd2, 6'b000000, 32'd3);
        cyc(0,0,1,0,0,1,0, 3'd3, 6'b000000, 32'd3);
        cyc(0,0,1,0,0,1,0, 3'd5, 6'b000011, 32'd3);
        cyc(0,0,1,0,0,1,1, 3'd0, 6'b000000, 32'd4);
        // fetch timeout
        cyc(0,1,0,0,0,0,0, 3'd0, 6'b000000, 32'd4);
        for (int i = 0; i < 5; i++) cyc(0,1,0,0,0,0,0, 3'd1, 6'b100000, 32'd4);
        cyc(0,1,0,0,0,1,1, 3'd7, 6'b000000, 32'd4);
        cyc(0,1,0,0,0,1,1, 3'd7, 6'b000000, 32'd4);
        // reset out of ERR, then ack on the limit cycle
        cyc(1,1,0,0,0,0,0, 3'd0, 6'b000000, 32'd0);
        cyc(0,1,1,0,0,0,0, 3'd0, 6'b000000, 32'd0);
        for (int i = 0; i < 4; i++) cyc(0,1,1,0,0,0,0, 3'd1, 6'b100000, 32'd0);
        cyc(0,1,1,0,0,1,0, 3'd1, 6'b110000, 32'd0);
        cyc(0,1,1,0,0,0,0, 3'd2, 6'b000000, 32'd0);
        cyc(0,1,1,0,0,0,0, 3'd3, 6'b000000, 32'd0);
        cyc(0,1,1,0,0,0,0, 3'd5, 6'b000011, 32'd0);
        // load interrupted by reset in MEM
        cyc(0,1,0,0,1,1,0, 3'd1, 6'b110000, 32'd1);
        cyc(0,1,0,0,1,0,0, 3'd2, 6'b000000, 32'd1);
        cyc(0,1,0,0,1,0,0, 3'd3, 6'b000000, 32'd1);
        cyc(1,1,0,0,1,0,1, 3'd0, 6'b000000, 32'd0);
        // restart
        cyc(0,1,1,0,0,1,0, 3'd0, 6'b000000, 32'd0);
        cyc(0,1,1,0,0,1,0, 3'd1, 6'b110000, 32'd0);
        cyc(0,1,1,0,0,1,0, 3'd2, 6'b000000, 32'd0);
        cyc(0,0,1,0,0,1,0, 3'd3, 6'b000000, 32'd0);
        cyc(0,0,1,0,0,1,0, 3'd5, 6'b000011, 32'd0);
        cyc(0,0,0,0,0,0,0, 3'd0, 6'b000000, 32'd1);
        // preload counter two below wrap
        @(posedge clk);
        #2 force dut.instret_q = 32'hFFFF_FFFE;
        #1 release dut.instret_q;
        cyc(0,1,1,0,0,1,0, 3'd0, 6'b000000, 32'hFFFF_FFFE);
        cyc(0,1,1,0,0,1,0, 3'd1, 6'b110000, 32'hFFFF_FFFE);
        cyc(0,1,1,0,0,1,0, 3'd2, 6'b000000, 32'hFFFF_FFFE);
        cyc(0,1,1,0,0,1,0, 3'd3, 6'b000000, 32'hFFFF_FFFE);
        cyc(0,1,1,0,0,1,0, 3'd5, 6'b000011, 32'hFFFF_FFFE);
        cyc(0,1,1,0,0,1,0, 3'd1, 6'b110000, 32'hFFFF_FFFF);
        cyc(0,1,1,0,0,1,0, 3'd2, 6'b000000, 32'hFFFF_FFFF);
        cyc(0,1,1,0,0,1,0, 3'd3, 6'b000000, 32'hFFFF_FFFF);
        cyc(0,0,1,0,0,1,0, 3'd5, 6'b000011, 32'hFFFF_FFFF);
        cyc(0,0,0,0,0,0,0, 3'd0, 6'b000000, 32'd0);

        for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
        n_checks++;
        if (expq.size() != 0) begin
            n_errs++;
            $display("FAIL drain: got %0d pending expected 0 pending", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
